// File: rtl/ncl_sync_bridge.sv
// Clocked valid/ready <-> four-phase NCL dual-rail bridge.
// TX: FIFO feeding DATA/NULL wavefronts. RX: synchronised rails with completion detection into a holding register.

module ncl_sync_bridge_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int W           = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [SYNC_STAGES-1:0][W-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];
endmodule

// One dual-rail bit: synchronise both rails, then classify the pair.
module ncl_sync_bridge_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rail_t,
  input  logic rail_f,
  output logic t_s,
  output logic is_data,
  output logic is_null,
  output logic is_ill
);
  logic [1:0] s;

  ncl_sync_bridge_sync #(.SYNC_STAGES(SYNC_STAGES), .W(2)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    ({rail_t, rail_f}),
    .q    (s)
  );

  assign t_s     = s[1];
  assign is_data = s[1] ^ s[0];
  assign is_null = ~|s;
  assign is_ill  = &s;
endmodule

module ncl_sync_bridge #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic [WIDTH-1:0] tx_t,
  output logic [WIDTH-1:0] tx_f,
  input  logic             tx_ki,
  input  logic [WIDTH-1:0] rx_t,
  input  logic [WIDTH-1:0] rx_f,
  output logic             rx_ko,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             rx_err,
  input  logic             err_clr
);
  // DEPTH=1 still gets a 1-bit index; the occupancy compare caps it at one entry.
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW    = $clog2(DEPTH) + 1;
  localparam int SLOTS = 1 << AW;

  typedef enum logic { T_NULL, T_DATA } tx_state_t;
  typedef enum logic { R_NULL, R_DATA } rx_state_t;

  // ---------------- TX path ----------------
  logic [SLOTS-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wptr, rptr, occ;
  logic [WIDTH-1:0]            head;
  logic                        full, empty, push, pop, ki_s;
  tx_state_t                   tx_state;

  ncl_sync_bridge_sync #(.SYNC_STAGES(SYNC_STAGES), .W(1)) u_ki_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (tx_ki),
    .q    (ki_s)
  );

  assign occ     = wptr - rptr;
  assign full    = (occ == PW'(DEPTH));
  assign empty   = (occ == '0);
  assign s_ready = !full;
  assign push    = s_valid & s_ready;
  assign pop     = (tx_state == T_NULL) & ki_s & !empty;
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= T_NULL;
      tx_t     <= '0;
      tx_f     <= '0;
    end else begin
      case (tx_state)
        T_NULL: if (pop) begin
          tx_t     <= head;
          tx_f     <= ~head;
          tx_state <= T_DATA;
        end
        T_DATA: if (!ki_s) begin
          tx_t     <= '0;
          tx_f     <= '0;
          tx_state <= T_NULL;
        end
        default: tx_state <= T_NULL;
      endcase
    end
  end

  // ---------------- RX path ----------------
  logic [WIDTH-1:0] rt_s, bit_data, bit_null, bit_ill;
  logic             complete, allnull, illegal, capture;
  rx_state_t        rx_state;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ncl_sync_bridge_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .rail_t (rx_t[i]),
      .rail_f (rx_f[i]),
      .t_s    (rt_s[i]),
      .is_data(bit_data[i]),
      .is_null(bit_null[i]),
      .is_ill (bit_ill[i])
    );
  end

  assign complete = &bit_data;
  assign allnull  = &bit_null;
  assign illegal  = |bit_ill;
  assign capture  = (rx_state == R_DATA) & complete & (!m_valid | m_ready);

  // Staying in R_DATA with rx_ko high is what backpressures the producer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= R_NULL;
      rx_ko    <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
    end else if (capture) begin
      m_data   <= rt_s;
      m_valid  <= 1'b1;
      rx_ko    <= 1'b0;
      rx_state <= R_NULL;
    end else begin
      if (m_valid & m_ready) m_valid <= 1'b0;
      if ((rx_state == R_NULL) & allnull) begin
        rx_ko    <= 1'b1;
        rx_state <= R_DATA;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rx_err <= 1'b0;
    else if (illegal) rx_err <= 1'b1;
    else if (err_clr) rx_err <= 1'b0;
  end
endmodule

// File: tb/tb_ncl_sync_bridge.sv
// Directed bench for ncl_sync_bridge: RX vector table, TX stream with model consumer, async reset.

module tb_ncl_sync_bridge;
  logic       clk, rst_n;
  logic       s_valid, s_ready;
  logic [7:0] s_data, tx_t, tx_f;
  logic       tx_ki;
  logic [7:0] rx_t, rx_f;
  logic       rx_ko, m_valid, m_ready;
  logic [7:0] m_data;
  logic       rx_err, err_clr;

  ncl_sync_bridge #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .tx_t(tx_t), .tx_f(tx_f), .tx_ki(tx_ki), .rx_t(rx_t), .rx_f(rx_f), .rx_ko(rx_ko),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .rx_err(rx_err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int comp_bad = 0, rail_viol = 0;
  logic cons_en = 1'b0;
  logic [7:0] got[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [7:0] t, f;
    logic       mr, clr;
    int         n;
    logic       ev, ek, ee;
    logic [7:0] ed;
  } rxv_t;

  rxv_t tbl[16];
  logic [7:0] txw[5];

  // Model NCL consumer: acknowledges each phase 3 cycles after seeing it.
  initial begin
    tx_ki = 1'b1;
    forever begin
      tick();
      if (cons_en && tx_ki && ((tx_t | tx_f) == 8'hFF) && ((tx_t & tx_f) == 8'h00)) begin
        got.push_back(tx_t);
        if (tx_f !== ~tx_t) comp_bad++;
        repeat (3) tick();
        tx_ki = 1'b0;
      end else if (cons_en && !tx_ki && tx_t == 8'h00 && tx_f == 8'h00) begin
        repeat (3) tick();
        tx_ki = 1'b1;
      end
    end
  end

  // Rails must always be a clean NULL or a clean complete DATA word.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if ((tx_t & tx_f) != 8'h00 || ((tx_t | tx_f) != 8'h00 && (tx_t | tx_f) != 8'hFF))
        rail_viol++;
    end
  end

  initial begin
    //          t      f      mr    clr   n   ev    ek    ee    ed
    tbl[0]  = '{8'h00, 8'h00, 1'b0, 1'b0, 4,  1'b0, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{8'h96, 8'h69, 1'b0, 1'b0, 2,  1'b0, 1'b1, 1'b0, 8'h00};
    tbl[2]  = '{8'h96, 8'h69, 1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, 8'h96};
    tbl[3]  = '{8'h00, 8'h00, 1'b0, 1'b0, 2,  1'b1, 1'b0, 1'b0, 8'h96};
    tbl[4]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 8'h96};
    tbl[5]  = '{8'h12, 8'hED, 1'b0, 1'b0, 6,  1'b1, 1'b1, 1'b0, 8'h96};
    tbl[6]  = '{8'h12, 8'hED, 1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b0, 8'h12};
    tbl[7]  = '{8'h00, 8'h00, 1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b0, 8'h12};
    tbl[8]  = '{8'h08, 8'h08, 1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b1, 8'h12};
    tbl[9]  = '{8'h08, 8'h08, 1'b0, 1'b1, 1,  1'b1, 1'b1, 1'b1, 8'h12};
    tbl[10] = '{8'h00, 8'h00, 1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b1, 8'h12};
    tbl[11] = '{8'h00, 8'h00, 1'b0, 1'b1, 1,  1'b1, 1'b1, 1'b0, 8'h12};
    tbl[12] = '{8'h00, 8'h00, 1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 8'h12};
    tbl[13] = '{8'h5A, 8'h25, 1'b0, 1'b0, 20, 1'b0, 1'b1, 1'b0, 8'h12};
    tbl[14] = '{8'h5A, 8'hA5, 1'b0, 1'b0, 2,  1'b0, 1'b1, 1'b0, 8'h12};
    tbl[15] = '{8'h5A, 8'hA5, 1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, 8'h5A};
    txw = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};

    s_valid = 1'b0; s_data = 8'h00; rx_t = 8'h00; rx_f = 8'h00;
    m_ready = 1'b0; err_clr = 1'b0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_tx_t", tx_t, 8'h00);
    chk("rst_tx_f", tx_f, 8'h00);
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_rx_ko", rx_ko, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 8'h00);
    chk("rst_rx_err", rx_err, 1'b0);
    rst_n = 1'b1;

    // RX table
    for (int i = 0; i < 16; i++) begin
      rx_t = tbl[i].t; rx_f = tbl[i].f; m_ready = tbl[i].mr; err_clr = tbl[i].clr;
      repeat (tbl[i].n) tick();
      chk($sformatf("rx%0d_m_valid", i), m_valid, tbl[i].ev);
      chk($sformatf("rx%0d_rx_ko", i), rx_ko, tbl[i].ek);
      chk($sformatf("rx%0d_rx_err", i), rx_err, tbl[i].ee);
      chk($sformatf("rx%0d_m_data", i), m_data, tbl[i].ed);
    end
    m_ready = 1'b0; err_clr = 1'b0;

    // TX stream: five back-to-back pushes into a 4-deep FIFO
    cons_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = txw[i];
      chk($sformatf("tx_s_ready_push%0d", i), s_ready, 1'b1);
      tick();
      if (i == 0) chk("tx_null_after_push", tx_t, 8'h00);
      if (i == 1) chk("tx_data_latency", tx_t, 8'hA5);
    end
    s_valid = 1'b0;
    chk("tx_full_s_ready", s_ready, 1'b0);
    begin
      int budget = 0;
      while (!(got.size() == 5 && tx_ki && tx_t == 8'h00 && tx_f == 8'h00) && budget < 1000) begin
        tick();
        budget++;
      end
      chk("tx_stream_timeout", budget < 1000, 1'b1);
    end
    cons_en = 1'b0;
    for (int i = 0; i < 5; i++)
      chk($sformatf("tx_word%0d", i), (i < got.size()) ? {24'h0, got[i]} : 32'hDEAD, {24'h0, txw[i]});
    chk("tx_complement", comp_bad, 0);
    chk("tx_rails_clean", rail_viol, 0);
    chk("tx_s_ready_drained", s_ready, 1'b1);

    // Async reset mid-word with queued FIFO contents and a held RX word
    s_valid = 1'b1; s_data = 8'h5A; tick();
    s_data = 8'hC3; tick();
    s_data = 8'h11; tick();
    s_valid = 1'b0;
    chk("pre_rst_tx_t", tx_t, 8'h5A);
    chk("pre_rst_m_valid", m_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx_t", tx_t, 8'h00);
    chk("arst_tx_f", tx_f, 8'h00);
    chk("arst_s_ready", s_ready, 1'b1);
    chk("arst_rx_ko", rx_ko, 1'b0);
    chk("arst_m_valid", m_valid, 1'b0);
    chk("arst_m_data", m_data, 8'h00);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chk("post_rst_fifo_discard", tx_t, 8'h00);
    chk("post_rst_s_ready", s_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
